// File: rtl/apb_master_arbiter_if.sv
// Bundle of requester-side command/response signals and the apb_master command port.
// Latency: none; pure wiring container.
// Backpressure: carried by req_valid/req_ready and by the APB pready handshake.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Requester command side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;

  // Requester response side
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  // Command port towards apb_master
  logic                          transfer;
  logic                          read;
  logic                          write;
  logic [ADDR_WIDTH-1:0]         apb_paddr;
  logic [DATA_WIDTH-1:0]         apb_write_data;

  // Observed APB bus / master phase
  logic                          psel;
  logic                          penable;
  logic                          pready;
  logic                          pslverr;
  logic [DATA_WIDTH-1:0]         prdata;

  // Status
  logic                          timeout_clr;
  logic                          apb_timeout;
  logic                          busy;

  // Arbiter side: consumes requests and bus status, drives grants, responses and commands
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output transfer, read, write, apb_paddr, apb_write_data,
    input  psel, penable, pready, pslverr, prdata,
    input  timeout_clr,
    output apb_timeout, busy
  );

  // Environment side: requesters, apb_master and the APB slave
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  transfer, read, write, apb_paddr, apb_write_data,
    output psel, penable, pready, pslverr, prdata,
    output timeout_clr,
    input  apb_timeout, busy
  );

endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one apb_master command port between NUM_REQ requesters.
// Latency: grant to rsp_valid is 4 cycles plus slave wait states; back-to-back grants 5 cycles apart.
// Backpressure: one command in flight; other requesters hold req_valid until their req_ready pulse.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                  pclock,
  input logic                  presetn,
  apb_master_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  arb_state_t             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       owner;
  logic                   cmd_write;
  logic [CNT_W-1:0]       wait_cnt;

  logic                   cmpl;
  logic                   setup_seen;
  logic                   timeout_set;

  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic                   sel_write;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  // Requester index modulo NUM_REQ, used by the wrapping round-robin search.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // ACCESS phase finishing this cycle, and the master sitting in SETUP for our command.
  assign cmpl       = bus.psel & bus.penable & bus.pready;
  assign setup_seen = bus.psel & ~bus.penable;

  // The counter hits the limit on this cycle's increment while the slave is still stalling.
  assign timeout_set = (state == ARB_WAIT) && !cmpl && (wait_cnt == CNT_LAST);

  // Round-robin search starting one past the last winner, wrapping through all requesters.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld && bus.req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
        win_vld = 1'b1;
        win_idx = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  // Pick the winner's command fields out of the flattened request buses.
  always_comb begin
    sel_write = bus.req_write[win_idx];
    sel_addr  = bus.req_addr[int'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = bus.req_wdata[int'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
  end

  // Arbitration and command sequencing FSM; every bus-facing output is a register here.
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      state              <= ARB_IDLE;
      rr_ptr             <= IDX_W'(NUM_REQ - 1);
      owner              <= '0;
      cmd_write          <= 1'b0;
      bus.req_ready      <= '0;
      bus.rsp_valid      <= '0;
      bus.rsp_rdata      <= '0;
      bus.rsp_err        <= 1'b0;
      bus.transfer       <= 1'b0;
      bus.read           <= 1'b0;
      bus.write          <= 1'b0;
      bus.apb_paddr      <= '0;
      bus.apb_write_data <= '0;
      bus.busy           <= 1'b0;
    end else begin
      // Grant and completion are single-cycle pulses.
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;

      case (state)
        // RESP arbitrates as well as IDLE so a requester re-asserting alongside its
        // rsp_valid is granted on the very next cycle (5-cycle command spacing).
        ARB_IDLE, ARB_RESP: begin
          bus.transfer <= 1'b0;
          if (win_vld) begin
            owner              <= win_idx;
            rr_ptr             <= win_idx;
            cmd_write          <= sel_write;
            bus.req_ready      <= ONE_HOT0 << win_idx;
            bus.write          <= sel_write;
            bus.read           <= ~sel_write;
            bus.apb_paddr      <= sel_addr;
            bus.apb_write_data <= sel_write ? sel_wdata : '0;
            bus.busy           <= 1'b1;
            state              <= ARB_ISSUE;
          end else begin
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            bus.busy  <= 1'b0;
            state     <= ARB_IDLE;
          end
        end

        // Hold transfer until the master shows SETUP, then drop it so exactly one
        // SETUP/ACCESS pair is performed for this command.
        ARB_ISSUE: begin
          bus.transfer <= ~setup_seen;
          if (setup_seen) begin
            state <= ARB_WAIT;
          end
        end

        // Command fields stay stable until the slave completes the ACCESS phase.
        ARB_WAIT: begin
          bus.transfer <= 1'b0;
          if (cmpl) begin
            bus.rsp_valid <= ONE_HOT0 << owner;
            bus.rsp_rdata <= cmd_write ? '0 : bus.prdata;
            bus.rsp_err   <= bus.pslverr;
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            state         <= ARB_RESP;
          end
        end

        default: begin
          bus.transfer <= 1'b0;
          bus.read     <= 1'b0;
          bus.write    <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= ARB_IDLE;
        end
      endcase
    end
  end

  // ACCESS-wait counter: counts stalled cycles, saturates, clears once the transfer completes.
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= '0;
    end else if (state == ARB_WAIT) begin
      if (cmpl) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky timeout flag; a set on the same cycle as timeout_clr takes priority.
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      bus.apb_timeout <= 1'b0;
    end else if (timeout_set) begin
      bus.apb_timeout <= 1'b1;
    end else if (bus.timeout_clr) begin
      bus.apb_timeout <= 1'b0;
    end
  end

endmodule
